// File: rtl/aes_key_sched_pkg.sv
// Shared AES definitions: round count, round-constant table and key-schedule state encoding.
package aes_key_sched_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ks_state_e;

    // Indexed directly by round number; rounds 0 and 11..15 carry no constant.
    localparam logic [7:0] RCON_TBL [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        return RCON_TBL[rnd];
    endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Round-controller <-> key-schedule connection: controller drives sequencing and key, schedule returns the round key.
interface aes_key_sched_if;

    logic         start;
    logic         accept;
    logic [3:0]   rndNo;
    logic         enbKS;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic         key_valid;
    logic         seq_err;

    modport master (
        output start, accept, rndNo, enbKS, key_in,
        input  round_key, key_valid, seq_err
    );

    modport slave (
        input  start, accept, rndNo, enbKS, key_in,
        output round_key, key_valid, seq_err
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, shared by the key schedule's SubWord and the core's SubBytes.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX_TBL[i_byte];

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 on-the-fly key schedule: one expansion step per round, round key presented in the same cycle as its round.
//
// state     | meaning
// ST_IDLE   | no schedule in progress; any expansion request is a sequence error
// ST_ACTIVE | key loaded, r_exp_rnd holds the next round expected from the controller
module aes_key_sched
    import aes_key_sched_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    aes_key_sched_if.slave ks
);

    ks_state_e    r_state;
    ks_state_e    w_state_nxt;
    logic [127:0] r_key_reg;
    logic [3:0]   r_exp_rnd;
    logic [3:0]   w_exp_rnd_nxt;
    logic         r_seq_err;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_sub, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_expanded;
    logic [127:0] w_round_key;
    logic         w_rnd_in_range;
    logic         w_match;
    logic         w_key_valid;
    logic         w_err;
    logic         w_load;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key_reg;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t        = w_sub ^ {rcon(ks.rndNo), 24'h0};
    assign w_n0       = w_w0 ^ w_t;
    assign w_n1       = w_w1 ^ w_n0;
    assign w_n2       = w_w2 ^ w_n1;
    assign w_n3       = w_w3 ^ w_n2;
    assign w_expanded = {w_n0, w_n1, w_n2, w_n3};

    assign w_rnd_in_range = (ks.rndNo != 4'd0) && (ks.rndNo <= NR);

    // accept wins over expansion so a reload can land in any round slot.
    always_comb begin
        w_round_key = r_key_reg;
        if (ks.enbKS && w_rnd_in_range) begin
            w_round_key = w_expanded;
        end
        if (ks.accept) begin
            w_round_key = ks.key_in;
        end
    end

    assign w_match     = (r_state == ST_ACTIVE) && ks.enbKS && (ks.rndNo == r_exp_rnd);
    assign w_key_valid = ks.accept || w_match;
    assign w_err       = ks.start &&
                         ((ks.enbKS && ((r_state == ST_IDLE) || (ks.rndNo != r_exp_rnd))) ||
                          (ks.rndNo > NR));
    assign w_load      = ks.start && !w_err && (ks.accept || (ks.enbKS && w_key_valid));

    always_comb begin
        w_state_nxt = r_state;
        if (ks.start) begin
            case (r_state)
                ST_IDLE: begin
                    if (ks.accept) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (ks.accept) begin
                        w_state_nxt = ST_ACTIVE;
                    end else if (ks.enbKS && (ks.rndNo == NR)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Erroneous cycles leave the round tracker untouched so the controller can resynchronise.
    always_comb begin
        w_exp_rnd_nxt = r_exp_rnd;
        if (ks.start && !w_err) begin
            if (ks.accept) begin
                w_exp_rnd_nxt = 4'd1;
            end else if (r_state == ST_IDLE) begin
                w_exp_rnd_nxt = 4'd0;
            end else if (w_match) begin
                w_exp_rnd_nxt = r_exp_rnd + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_reg <= '0;
            r_exp_rnd <= '0;
            r_seq_err <= 1'b0;
        end else begin
            r_exp_rnd <= w_exp_rnd_nxt;
            if (w_load) begin
                r_key_reg <= w_round_key;
            end
            if (w_err) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign ks.round_key = w_round_key;
    assign ks.key_valid = w_key_valid;
    assign ks.seq_err   = r_seq_err;

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched against a word-level FIPS-197 key expansion built from GF(2^8) arithmetic.
module tb_aes_key_sched;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0]   sb [256];
    logic [127:0] mdl_rk [11];

    aes_key_sched_if ks_if ();

    aes_key_sched dut (
        .clk (clk),
        .rst (rst),
        .ks  (ks_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_sched(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic rs, input logic s, input logic a, input logic [3:0] r,
                         input logic e, input logic [127:0] k);
        @(negedge clk);
        rst          = rs;
        ks_if.start  = s;
        ks_if.accept = a;
        ks_if.rndNo  = r;
        ks_if.enbKS  = e;
        ks_if.key_in = k;
        #1;
    endtask

    task automatic run_rounds(input int first, input int last, input int stall_at, input int stall_len);
        for (int r = first; r <= last; r++) begin
            if (r == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    drive(1'b0, 1'b0, 1'b0, r[3:0], 1'b1, rand_key());
                    checks++;
                    if (ks_if.round_key !== mdl_rk[r] || ks_if.key_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold rnd=%0d got %h/%b want %h/1", r, ks_if.round_key, ks_if.key_valid, mdl_rk[r]);
                    end
                end
            end
            drive(1'b0, 1'b1, 1'b0, r[3:0], 1'b1, rand_key());
            checks++;
            if (ks_if.round_key !== mdl_rk[r] || ks_if.key_valid !== 1'b1 || ks_if.seq_err !== 1'b0) begin
                errors++;
                $display("FAIL round_key rnd=%0d got %h v=%b e=%b want %h v=1 e=0",
                         r, ks_if.round_key, ks_if.key_valid, ks_if.seq_err, mdl_rk[r]);
            end
        end
    endtask

    task automatic run_schedule(input logic [127:0] key, input logic [3:0] acc_rnd,
                                input int stall_at, input int stall_len, input int last_rnd);
        build_sched(key);
        drive(1'b0, 1'b1, 1'b1, acc_rnd, 1'b0, key);
        checks++;
        if (ks_if.round_key !== key || ks_if.key_valid !== 1'b1) begin
            errors++;
            $display("FAIL accept_key got %h v=%b want %h v=1", ks_if.round_key, ks_if.key_valid, key);
        end
        run_rounds(1, last_rnd, stall_at, stall_len);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, rand_key());
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, rand_key());
        checks++;
        if (ks_if.round_key !== 128'h0 || ks_if.key_valid !== 1'b0 || ks_if.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got %h v=%b e=%b want 0 v=0 e=0", ks_if.round_key, ks_if.key_valid, ks_if.seq_err);
        end
    endtask

    task automatic test_fips_a1();
        run_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 4'd1, 1'b1, rand_key());
        checks++;
        if (ks_if.round_key !== 128'ha0fafe1788542cb123a339392a6c7605 || ks_if.key_valid !== 1'b1) begin
            errors++;
            $display("FAIL a1_round1 got %h want a0fafe1788542cb123a339392a6c7605", ks_if.round_key);
        end
        run_rounds(2, 9, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 4'd10, 1'b1, rand_key());
        checks++;
        if (ks_if.round_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || ks_if.key_valid !== 1'b1 || ks_if.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL a1_round10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", ks_if.round_key);
        end
    endtask

    task automatic test_back_to_back();
        run_schedule(128'h000102030405060708090a0b0c0d0e0f, 4'd0, 0, 0, 9);
        drive(1'b0, 1'b1, 1'b0, 4'd10, 1'b1, rand_key());
        checks++;
        if (ks_if.round_key !== 128'h13111d7fe3944a17f307a78b4d2b30c5 || ks_if.key_valid !== 1'b1 || ks_if.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_round10 got %h want 13111d7fe3944a17f307a78b4d2b30c5", ks_if.round_key);
        end
    endtask

    task automatic test_stall();
        run_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0, 5, 3, 10);
    endtask

    task automatic test_abort();
        run_schedule(rand_key(), 4'd0, 0, 0, 3);
        run_schedule(rand_key(), 4'd4, 0, 0, 10);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            run_schedule(rand_key(), 4'd0, $urandom_range(1, 10), $urandom_range(0, 4), 10);
        end
    endtask

    task automatic test_errors();
        logic [127:0] last;
        last = mdl_rk[10];
        drive(1'b0, 1'b1, 1'b0, 4'd3, 1'b1, rand_key());
        checks++;
        if (ks_if.key_valid !== 1'b0 || ks_if.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_enb_valid got v=%b e=%b want v=0 e=0", ks_if.key_valid, ks_if.seq_err);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, rand_key());
        checks++;
        if (ks_if.seq_err !== 1'b1 || ks_if.round_key !== last) begin
            errors++;
            $display("FAIL idle_enb_err got e=%b key=%h want e=1 key=%h", ks_if.seq_err, ks_if.round_key, last);
        end
        test_reset();
        run_schedule(rand_key(), 4'd0, 0, 0, 2);
        drive(1'b0, 1'b1, 1'b0, 4'd4, 1'b1, rand_key());
        checks++;
        if (ks_if.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL skip_valid got %b want 0", ks_if.key_valid);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd3, 1'b1, rand_key());
        checks++;
        if (ks_if.seq_err !== 1'b1 || ks_if.key_valid !== 1'b1 || ks_if.round_key !== mdl_rk[3]) begin
            errors++;
            $display("FAIL skip_resync got e=%b v=%b key=%h want e=1 v=1 key=%h",
                     ks_if.seq_err, ks_if.key_valid, ks_if.round_key, mdl_rk[3]);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, rand_key());
        run_schedule(rand_key(), 4'd0, 0, 0, 6);
        drive(1'b1, 1'b1, 1'b0, 4'd7, 1'b1, rand_key());
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, rand_key());
        checks++;
        if (ks_if.round_key !== 128'h0 || ks_if.seq_err !== 1'b0 || ks_if.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got %h e=%b v=%b want 0 e=0 v=0", ks_if.round_key, ks_if.seq_err, ks_if.key_valid);
        end
        drive(1'b0, 1'b1, 1'b0, 4'd1, 1'b1, rand_key());
        checks++;
        if (ks_if.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle got v=%b want 0", ks_if.key_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, rand_key());
        checks++;
        if (ks_if.seq_err !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_flag got %b want 1", ks_if.seq_err);
        end
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, rand_key());
        run_schedule(rand_key(), 4'd0, 0, 0, 10);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        ks_if.start  = 1'b0;
        ks_if.accept = 1'b0;
        ks_if.rndNo  = 4'd0;
        ks_if.enbKS  = 1'b0;
        ks_if.key_in = '0;
        build_sbox();
        test_reset();
        test_fips_a1();
        test_back_to_back();
        test_stall();
        test_abort();
        test_random();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
